// File: rtl/shifter_frame_sequencer.sv
// rtl/shifter_frame_sequencer.sv - frame header parser and sample sequencer for the spectral shifter
//
// Purpose: parses a 4-word frame header (freq lo, freq hi, mode, reserved), holds the
// shifter configuration for the frame, forwards payload words as one-cycle sample strobes,
// tracks samples in flight through the shifter, pulses flush once everything has drained,
// then blocks input until the output packer reports done.
//
// Ports:
//   i_clk, i_rst                          clock, synchronous active-high reset
//   i_word_valid/i_word/i_word_last       input word stream (header + payload)
//   o_in_ready                            input accepted when i_word_valid & o_in_ready
//   o_frequency, o_switch, o_cfg_valid    shifter configuration for the current frame
//   o_sample_valid, o_sample              forwarded payload sample strobe
//   i_shifter_valid                       one pulse per sample leaving the shifter
//   o_flush                               one-cycle pulse when the frame has fully drained
//   i_out_done                            output packer finished the frame
//   o_busy, o_sample_count                status
//   o_err_short, o_err_overflow           sticky per-frame error flags

module shifter_frame_sequencer #(
   parameter int DATA_WIDTH  = 16,
   parameter int MAX_SAMPLES = 252,
   parameter int CNT_WIDTH   = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_word_valid,
   input  logic [DATA_WIDTH-1:0] i_word,
   input  logic                  i_word_last,
   output logic                  o_in_ready,
   output logic [31:0]           o_frequency,
   output logic                  o_switch,
   output logic                  o_cfg_valid,
   output logic                  o_sample_valid,
   output logic [DATA_WIDTH-1:0] o_sample,
   input  logic                  i_shifter_valid,
   output logic                  o_flush,
   input  logic                  i_out_done,
   output logic                  o_busy,
   output logic [CNT_WIDTH-1:0]  o_sample_count,
   output logic                  o_err_short,
   output logic                  o_err_overflow
);

   typedef enum logic [2:0] {
      H_FLO, H_FHI, H_MODE, H_RSVD, STREAM, DRAIN, WAIT_OUT
   } state_t;

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_SAMPLES);

   state_t               state;
   logic [CNT_WIDTH-1:0] in_flight;
   logic [CNT_WIDTH-1:0] in_flight_nxt;
   logic                 accept;

   assign o_in_ready = (state != DRAIN) && (state != WAIT_OUT);
   assign o_busy     = (state != H_FLO);
   assign accept     = i_word_valid & o_in_ready;

   // A sample entering and one leaving in the same cycle cancel out; an echo with
   // nothing in flight is spurious and must not wrap the counter.
   always_comb begin
      in_flight_nxt = in_flight;
      if (o_sample_valid && !i_shifter_valid)
         in_flight_nxt = in_flight + 1'b1;
      else if (!o_sample_valid && i_shifter_valid && (in_flight != '0))
         in_flight_nxt = in_flight - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= H_FLO;
         o_frequency    <= '0;
         o_switch       <= 1'b0;
         o_cfg_valid    <= 1'b0;
         o_sample_valid <= 1'b0;
         o_sample       <= '0;
         o_flush        <= 1'b0;
         o_sample_count <= '0;
         o_err_short    <= 1'b0;
         o_err_overflow <= 1'b0;
         in_flight      <= '0;
      end else begin
         o_sample_valid <= 1'b0;
         o_flush        <= 1'b0;
         in_flight      <= in_flight_nxt;

         case (state)
            H_FLO: begin
               if (accept) begin
                  o_frequency[15:0] <= i_word[15:0];
                  o_sample_count    <= '0;
                  o_err_overflow    <= 1'b0;
                  // A frame ending on its first word is still a short frame.
                  o_err_short       <= i_word_last;
                  state             <= i_word_last ? DRAIN : H_FHI;
               end
            end
            H_FHI: begin
               if (accept) begin
                  o_frequency[31:16] <= i_word[15:0];
                  if (i_word_last) o_err_short <= 1'b1;
                  state <= i_word_last ? DRAIN : H_MODE;
               end
            end
            H_MODE: begin
               if (accept) begin
                  o_switch <= i_word[0];
                  if (i_word_last) o_err_short <= 1'b1;
                  state <= i_word_last ? DRAIN : H_RSVD;
               end
            end
            H_RSVD: begin
               if (accept) begin
                  // Reserved word is dropped; config only becomes valid on a full header.
                  if (i_word_last) begin
                     o_err_short <= 1'b1;
                     state       <= DRAIN;
                  end else begin
                     o_cfg_valid <= 1'b1;
                     state       <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (accept) begin
                  if (o_sample_count < MAX_CNT) begin
                     o_sample       <= i_word;
                     o_sample_valid <= 1'b1;
                     o_sample_count <= o_sample_count + 1'b1;
                  end else begin
                     o_err_overflow <= 1'b1;
                  end
                  if (i_word_last) state <= DRAIN;
               end
            end
            DRAIN: begin
               // Look at the post-update count so the flush follows the final echo by
               // one cycle; a strobe still in the output register is not yet counted.
               if ((in_flight_nxt == '0) && !o_sample_valid) begin
                  o_flush <= 1'b1;
                  state   <= WAIT_OUT;
               end
            end
            WAIT_OUT: begin
               if (i_out_done) begin
                  o_cfg_valid <= 1'b0;
                  state       <= H_FLO;
               end
            end
            default: state <= H_FLO;
         endcase
      end
   end

endmodule

// File: tb/tb_shifter_frame_sequencer.sv
// tb/tb_shifter_frame_sequencer.sv - scoreboard bench for shifter_frame_sequencer

module tb_shifter_frame_sequencer;

   localparam int DW   = 16;
   localparam int MAXS = 4;
   localparam int CW   = 10;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_word_valid = 1'b0;
   logic [DW-1:0] i_word = '0;
   logic          i_word_last = 1'b0;
   logic          o_in_ready;
   logic [31:0]   o_frequency;
   logic          o_switch;
   logic          o_cfg_valid;
   logic          o_sample_valid;
   logic [DW-1:0] o_sample;
   logic          i_shifter_valid = 1'b0;
   logic          o_flush;
   logic          i_out_done = 1'b0;
   logic          o_busy;
   logic [CW-1:0] o_sample_count;
   logic          o_err_short;
   logic          o_err_overflow;

   always #5 i_clk = ~i_clk;

   shifter_frame_sequencer #(
      .DATA_WIDTH (DW),
      .MAX_SAMPLES(MAXS),
      .CNT_WIDTH  (CW)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_word_valid   (i_word_valid),
      .i_word         (i_word),
      .i_word_last    (i_word_last),
      .o_in_ready     (o_in_ready),
      .o_frequency    (o_frequency),
      .o_switch       (o_switch),
      .o_cfg_valid    (o_cfg_valid),
      .o_sample_valid (o_sample_valid),
      .o_sample       (o_sample),
      .i_shifter_valid(i_shifter_valid),
      .o_flush        (o_flush),
      .i_out_done     (i_out_done),
      .o_busy         (o_busy),
      .o_sample_count (o_sample_count),
      .o_err_short    (o_err_short),
      .o_err_overflow (o_err_overflow)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int flush_cnt = 0;
   int echo_delay = 4;
   logic [DW-1:0] exp_q[$];
   int flush_q[$];
   int due_q[$];

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops expected samples and expected flush cycles as the DUT presents them.
   initial forever begin
      @(negedge i_clk);
      if (o_sample_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_sample actual=0x%0h expected=none", o_sample);
         end else begin
            chk("sample", 32'(o_sample), 32'(exp_q.pop_front()));
         end
      end
      if (o_flush) begin
         flush_cnt++;
         if (flush_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_flush actual_cycle=%0d expected=none", cyc);
         end else begin
            chk("flush_cycle", 32'(cyc), 32'(flush_q.pop_front()));
         end
      end
   end

   // Shifter model: echoes each sample echo_delay cycles after its strobe.
   initial forever begin
      @(negedge i_clk);
      i_shifter_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         void'(due_q.pop_front());
         i_shifter_valid = 1'b1;
      end
      if (o_sample_valid) due_q.push_back(cyc + echo_delay);
   end

   task automatic send(input logic [DW-1:0] w, input bit last, output int acc);
      int t = 0;
      while (!o_in_ready && t < 200) begin
         @(negedge i_clk);
         t++;
      end
      if (!o_in_ready) begin
         checks++; errors++;
         $display("FAIL in_ready_timeout actual=0 expected=1");
      end
      i_word_valid = 1'b1;
      i_word       = w;
      i_word_last  = last;
      acc          = cyc;
      @(negedge i_clk);
      i_word_valid = 1'b0;
      i_word_last  = 1'b0;
   endtask

   task automatic header(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] mode);
      int a;
      send(lo, 1'b0, a);
      send(hi, 1'b0, a);
      send(mode, 1'b0, a);
      send(16'h0000, 1'b0, a);
   endtask

   task automatic wait_flush();
      int start = flush_cnt;
      int t = 0;
      while (flush_cnt == start && t < 500) begin
         @(negedge i_clk);
         t++;
      end
      if (flush_cnt == start) begin
         checks++; errors++;
         $display("FAIL flush_timeout actual=none expected=flush");
      end
      @(negedge i_clk);
   endtask

   task automatic out_done();
      chk("wait_out_in_ready", 32'(o_in_ready), 32'd0);
      chk("wait_out_busy", 32'(o_busy), 32'd1);
      repeat (2) @(negedge i_clk);
      i_out_done = 1'b1;
      @(negedge i_clk);
      i_out_done = 1'b0;
      chk("done_busy", 32'(o_busy), 32'd0);
      chk("done_cfg_valid", 32'(o_cfg_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a3, a5;

      // 1: reset held 3 cycles
      repeat (3) @(negedge i_clk);
      chk("rst_in_ready", 32'(o_in_ready), 32'd1);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_frequency", o_frequency, 32'd0);
      chk("rst_switch", 32'(o_switch), 32'd0);
      chk("rst_cfg_valid", 32'(o_cfg_valid), 32'd0);
      chk("rst_sample_valid", 32'(o_sample_valid), 32'd0);
      chk("rst_flush", 32'(o_flush), 32'd0);
      chk("rst_count", 32'(o_sample_count), 32'd0);
      chk("rst_errs", {30'd0, o_err_short, o_err_overflow}, 32'd0);
      i_rst = 1'b0;
      @(negedge i_clk);

      // 2: normal frame, 3 samples, echo after 4 cycles
      echo_delay = 4;
      header(16'h5678, 16'h1234, 16'h0001);
      chk("t2_cfg_valid", 32'(o_cfg_valid), 32'd1);
      chk("t2_frequency", o_frequency, 32'h1234_5678);
      chk("t2_switch", 32'(o_switch), 32'd1);
      exp_q.push_back(16'h0A01); send(16'h0A01, 1'b0, a);
      exp_q.push_back(16'h0A02); send(16'h0A02, 1'b0, a);
      exp_q.push_back(16'h0A03); send(16'h0A03, 1'b1, a);
      flush_q.push_back(a + 2 + 4);
      wait_flush();
      chk("t2_count", 32'(o_sample_count), 32'd3);
      out_done();
      chk("t2_freq_hold", o_frequency, 32'h1234_5678);
      chk("t2_count_hold", 32'(o_sample_count), 32'd3);

      // 3: last on mode word
      send(16'hAAAA, 1'b0, a);
      send(16'hBBBB, 1'b0, a);
      send(16'h0000, 1'b1, a);
      flush_q.push_back(a + 2);
      chk("t3_err_short", 32'(o_err_short), 32'd1);
      chk("t3_cfg_valid", 32'(o_cfg_valid), 32'd0);
      wait_flush();
      chk("t3_cfg_valid_end", 32'(o_cfg_valid), 32'd0);
      chk("t3_count", 32'(o_sample_count), 32'd0);
      chk("t3_frequency", o_frequency, 32'hBBBB_AAAA);
      out_done();

      // 4: overflow, 6 payload words with MAX_SAMPLES=4
      header(16'h0001, 16'h0000, 16'h0000);
      chk("t4_err_short_cleared", 32'(o_err_short), 32'd0);
      a3 = 0; a5 = 0;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) exp_q.push_back(16'h0B00 + 16'(i));
         send(16'h0B00 + 16'(i), (i == 5), a);
         if (i == 3) a3 = a;
         if (i == 5) a5 = a;
      end
      flush_q.push_back((a3 + 6 > a5 + 2) ? a3 + 6 : a5 + 2);
      chk("t4_err_overflow", 32'(o_err_overflow), 32'd1);
      wait_flush();
      chk("t4_count", 32'(o_sample_count), 32'd4);
      out_done();

      // 5: strobe and echo coincide (echo 1 cycle after strobe)
      echo_delay = 1;
      header(16'h0005, 16'h0000, 16'h0001);
      chk("t5_err_overflow_cleared", 32'(o_err_overflow), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(16'h0C00 + 16'(i));
         send(16'h0C00 + 16'(i), (i == 4), a);
      end
      flush_q.push_back(a + 2 + 1);
      wait_flush();
      chk("t5_count", 32'(o_sample_count), 32'd4);
      out_done();

      // 6: reset in STREAM with two samples in flight
      echo_delay = 20;
      header(16'h1111, 16'h2222, 16'h0001);
      exp_q.push_back(16'h0D01); send(16'h0D01, 1'b0, a);
      exp_q.push_back(16'h0D02); send(16'h0D02, 1'b0, a);
      repeat (3) @(negedge i_clk);
      i_rst = 1'b1;
      due_q.delete();
      repeat (2) @(negedge i_clk);
      chk("t6_busy", 32'(o_busy), 32'd0);
      chk("t6_in_ready", 32'(o_in_ready), 32'd1);
      chk("t6_cfg_valid", 32'(o_cfg_valid), 32'd0);
      chk("t6_count", 32'(o_sample_count), 32'd0);
      chk("t6_frequency", o_frequency, 32'd0);
      i_rst = 1'b0;
      @(negedge i_clk);
      echo_delay = 4;
      header(16'h3333, 16'h4444, 16'h0000);
      chk("t6_frequency_new", o_frequency, 32'h4444_3333);
      exp_q.push_back(16'h0E01); send(16'h0E01, 1'b1, a);
      flush_q.push_back(a + 2 + 4);
      wait_flush();
      chk("t6_count_new", 32'(o_sample_count), 32'd1);
      out_done();

      repeat (5) @(negedge i_clk);
      chk("end_samples_pending", 32'(exp_q.size()), 32'd0);
      chk("end_flush_pending", 32'(flush_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
